// File: rtl/systolic_input_feeder.sv
// Input feeder for pe_array: accepts activation/weight beats, applies the diagonal
// lane skew, drains zeros after the last beat of a tile and pulses tile_done.
module systolic_input_feeder #(
  parameter int unsigned ARRAY_SIZE         = 2,
  parameter int unsigned COMPUTE_DATA_WIDTH = 4,
  parameter int unsigned DRAIN_CYCLES       = 2 * ARRAY_SIZE - 1,
  parameter int unsigned MAX_BEATS          = 255,
  localparam int unsigned BEAT_W            = $clog2(MAX_BEATS + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_last,
  input  logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] in_acts,
  input  logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] in_weights,
  output logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] ins,
  output logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] weights_in,
  output logic                                          compute,
  output logic                                          busy,
  output logic                                          tile_done,
  output logic [BEAT_W-1:0]                             beat_count,
  output logic                                          overflow
);

  localparam int unsigned DW      = COMPUTE_DATA_WIDTH;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                compute_q, compute_d;
  logic                busy_q, busy_d;
  logic                tile_done_q, tile_done_d;
  logic                accept_c;

  assign accept_c = in_valid & in_ready_q;

  // Tile sequencing; outputs are registered copies of the next-state decode.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          beat_d  = BEAT_W'(1);
          state_d = in_last ? S_FLUSH : S_STREAM;
          if (in_last) drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      S_STREAM: begin
        if (accept_c) begin
          if (beat_q == BEAT_W'(MAX_BEATS)) ovf_d = 1'b1;
          else                              beat_d = beat_q + BEAT_W'(1);
          if (in_last) begin
            state_d = S_FLUSH;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end
      end
      S_FLUSH: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_STREAM);
    compute_d   = (state_d == S_STREAM) || (state_d == S_FLUSH);
    busy_d      = (state_d != S_IDLE);
    tile_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      beat_q      <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      compute_q   <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      beat_q      <= beat_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      compute_q   <= compute_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Lane i: head register plus i delay stages; zeros enter whenever no beat is accepted.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [i:0][DW-1:0] act_q, act_d, wgt_q, wgt_d;

    always_comb begin
      act_d    = act_q;
      wgt_d    = wgt_q;
      act_d[0] = accept_c ? in_acts[i]    : '0;
      wgt_d[0] = accept_c ? in_weights[i] : '0;
      for (int s = 1; s <= i; s++) begin
        act_d[s] = act_q[s-1];
        wgt_d[s] = wgt_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        act_q <= '0;
        wgt_q <= '0;
      end else begin
        act_q <= act_d;
        wgt_q <= wgt_d;
      end
    end

    assign ins[i]        = act_q[i];
    assign weights_in[i] = wgt_q[i];
  end

  assign in_ready   = in_ready_q;
  assign compute    = compute_q;
  assign busy       = busy_q;
  assign tile_done  = tile_done_q;
  assign beat_count = beat_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder: skew, drain timing, backpressure,
// async reset and beat-count saturation (second instance with MAX_BEATS=3).
module tb_systolic_input_feeder;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [1:0][3:0] in_acts = '0;
  logic [1:0][3:0] in_weights = '0;

  logic            in_ready, compute, busy, tile_done, overflow;
  logic [1:0][3:0] ins, weights_in;
  logic [7:0]      beat_count;

  logic            s_in_ready, s_compute, s_busy, s_tile_done, s_overflow;
  logic [1:0][3:0] s_ins, s_wts;
  logic [1:0]      s_beat_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  systolic_input_feeder #(
    .ARRAY_SIZE(2), .COMPUTE_DATA_WIDTH(4), .DRAIN_CYCLES(3), .MAX_BEATS(255)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_acts(in_acts), .in_weights(in_weights), .ins(ins), .weights_in(weights_in),
    .compute(compute), .busy(busy), .tile_done(tile_done), .beat_count(beat_count),
    .overflow(overflow)
  );

  systolic_input_feeder #(
    .ARRAY_SIZE(2), .COMPUTE_DATA_WIDTH(4), .DRAIN_CYCLES(3), .MAX_BEATS(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last),
    .in_acts(in_acts), .in_weights(in_weights), .ins(s_ins), .weights_in(s_wts),
    .compute(s_compute), .busy(s_busy), .tile_done(s_tile_done), .beat_count(s_beat_count),
    .overflow(s_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] w0, input logic [3:0] w1);
    in_valid      = v;
    in_last       = l;
    in_acts[0]    = a0;
    in_acts[1]    = a1;
    in_weights[0] = w0;
    in_weights[1] = w1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    rst = 1'b0;
    #3;
    vec_cnt++;
    if ({ins, weights_in, compute, busy, tile_done, beat_count, overflow} !== '0) begin
      err_cnt++;
      $display("FAIL reset_init: ins=%h w=%h cmp=%b busy=%b td=%b bc=%0d ovf=%b, want all 0",
               ins, weights_in, compute, busy, tile_done, beat_count, overflow);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    drive(1'b1, 1'b0, 4'd3, 4'd5, 4'd6, 4'd7);
    step();
    drive(1'b1, 1'b0, 4'd2, 4'd1, 4'd4, 4'd4);
    step();
    vec_cnt++;
    if (ins[0] !== 4'd2 || ins[1] !== 4'd5 || busy !== 1'b1 || beat_count !== 8'd2) begin
      err_cnt++;
      $display("FAIL reset_prestream: ins=%h busy=%b bc=%0d want ins=52 busy=1 bc=2",
               ins, busy, beat_count);
    end
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if ({ins, weights_in, compute, busy, tile_done, beat_count, overflow, s_beat_count} !== '0) begin
      err_cnt++;
      $display("FAIL reset_async: ins=%h w=%h cmp=%b busy=%b td=%b bc=%0d ovf=%b, want all 0",
               ins, weights_in, compute, busy, tile_done, beat_count, overflow);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || ins !== '0) begin
      err_cnt++;
      $display("FAIL reset_release: in_ready=%b busy=%b ins=%h want 1 0 00", in_ready, busy, ins);
    end
  endtask

  task automatic test_contiguous();
    logic [3:0] e_i0 [6] = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_i1 [6] = '{4'h0, 4'h2, 4'h5, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_w0 [6] = '{4'h3, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_w1 [6] = '{4'h0, 4'h4, 4'hD, 4'h0, 4'h0, 4'h0};
    logic       e_cp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       e_td [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      drive(1'b1, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4);
      else if (c == 1) drive(1'b1, 1'b1, 4'hF, 4'h5, 4'h2, 4'hD);
      else             drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      step();
      vec_cnt++;
      if (ins[0] !== e_i0[c] || ins[1] !== e_i1[c] || weights_in[0] !== e_w0[c] ||
          weights_in[1] !== e_w1[c] || compute !== e_cp[c] || tile_done !== e_td[c]) begin
        err_cnt++;
        $display("FAIL contig_c%0d: ins=%h w=%h cmp=%b td=%b want ins=%h%h w=%h%h cmp=%b td=%b",
                 c, ins, weights_in, compute, tile_done, e_i1[c], e_i0[c], e_w1[c], e_w0[c],
                 e_cp[c], e_td[c]);
      end
    end
    vec_cnt++;
    if (beat_count !== 8'd2) begin
      err_cnt++;
      $display("FAIL contig_count: beat_count=%0d want 2", beat_count);
    end
    step();
    vec_cnt++;
    if (tile_done !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL contig_after: td=%b in_ready=%b want 0 1", tile_done, in_ready);
    end
  endtask

  task automatic test_bubble();
    logic [3:0] e_i0 [8] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_i1 [8] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    logic       e_cp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       e_td [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      drive(1'b1, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1);
      else if (c == 3) drive(1'b1, 1'b1, 4'h2, 4'h2, 4'h2, 4'h2);
      else             drive(1'b0, 1'b1, 4'h9, 4'h9, 4'h9, 4'h9);
      step();
      vec_cnt++;
      if (ins[0] !== e_i0[c] || ins[1] !== e_i1[c] || weights_in[0] !== e_i0[c] ||
          compute !== e_cp[c] || tile_done !== e_td[c]) begin
        err_cnt++;
        $display("FAIL bubble_c%0d: ins=%h w0=%h cmp=%b td=%b want ins=%h%h cmp=%b td=%b",
                 c, ins, weights_in[0], compute, tile_done, e_i1[c], e_i0[c], e_cp[c], e_td[c]);
      end
    end
    vec_cnt++;
    if (beat_count !== 8'd2) begin
      err_cnt++;
      $display("FAIL bubble_count: beat_count=%0d want 2", beat_count);
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    step();
  endtask

  task automatic test_single();
    logic [3:0] e_i0 [6] = '{4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_i1 [6] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       e_cp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       e_td [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       e_rd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 4'h7, 4'h8, 4'h1, 4'h1);
      else        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      step();
      vec_cnt++;
      if (ins[0] !== e_i0[c] || ins[1] !== e_i1[c] || compute !== e_cp[c] ||
          tile_done !== e_td[c] || in_ready !== e_rd[c]) begin
        err_cnt++;
        $display("FAIL single_c%0d: ins=%h cmp=%b td=%b rdy=%b want ins=%h%h cmp=%b td=%b rdy=%b",
                 c, ins, compute, tile_done, in_ready, e_i1[c], e_i0[c], e_cp[c], e_td[c], e_rd[c]);
      end
    end
    vec_cnt++;
    if (beat_count !== 8'd1) begin
      err_cnt++;
      $display("FAIL single_count: beat_count=%0d want 1", beat_count);
    end
  endtask

  task automatic test_back_to_back();
    logic found;
    drive(1'b1, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1);
    step();
    drive(1'b1, 1'b1, 4'h2, 4'h2, 4'h2, 4'h2);
    step();
    drive(1'b1, 1'b0, 4'h4, 4'hE, 4'h5, 4'h5);
    for (int c = 2; c < 7; c++) begin
      step();
      vec_cnt++;
      if (ins[0] !== 4'h0 || beat_count !== 8'd2 || tile_done !== (c == 5) ||
          in_ready !== (c == 6)) begin
        err_cnt++;
        $display("FAIL b2b_hold_c%0d: ins0=%h bc=%0d td=%b rdy=%b want 0 2 %b %b",
                 c, ins[0], beat_count, tile_done, in_ready, c == 5, c == 6);
      end
    end
    step();
    vec_cnt++;
    if (beat_count !== 8'd1 || ins[0] !== 4'h4 || compute !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_accept: bc=%0d ins0=%h cmp=%b want 1 4 1", beat_count, ins[0], compute);
    end
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (tile_done === 1'b1) found = 1'b1;
    end
    vec_cnt++;
    if (found !== 1'b1 || beat_count !== 8'd2) begin
      err_cnt++;
      $display("FAIL b2b_done: tile_done seen=%b bc=%0d want 1 2", found, beat_count);
    end
    step();
  endtask

  task automatic test_saturation();
    logic found;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, c == 4, 4'(c + 1), 4'h0, 4'(c + 1), 4'h0);
      step();
      vec_cnt++;
      if (s_beat_count !== ((c < 3) ? 2'(c + 1) : 2'd3) || s_overflow !== (c >= 3)) begin
        err_cnt++;
        $display("FAIL sat_c%0d: bc=%0d ovf=%b want %0d %b", c, s_beat_count, s_overflow,
                 (c < 3) ? c + 1 : 3, c >= 3);
      end
    end
    vec_cnt++;
    if (beat_count !== 8'd5 || overflow !== 1'b0 || s_ins[0] !== 4'h5 || s_wts[0] !== 4'h5 ||
        s_compute !== 1'b1 || s_busy !== 1'b1 || s_in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL sat_wide: bc=%0d ovf=%b s_ins0=%h s_w0=%h cmp=%b busy=%b rdy=%b want 5 0 5 5 1 1 0",
               beat_count, overflow, s_ins[0], s_wts[0], s_compute, s_busy, s_in_ready);
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (s_tile_done === 1'b1) found = 1'b1;
    end
    step();
    vec_cnt++;
    if (found !== 1'b1 || s_overflow !== 1'b1 || s_beat_count !== 2'd3) begin
      err_cnt++;
      $display("FAIL sat_sticky: done=%b ovf=%b bc=%0d want 1 1 3", found, s_overflow, s_beat_count);
    end
    #2 rst = 1'b0;
    #1;
    vec_cnt++;
    if (s_overflow !== 1'b0 || s_beat_count !== 2'd0) begin
      err_cnt++;
      $display("FAIL sat_reset: ovf=%b bc=%0d want 0 0", s_overflow, s_beat_count);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_bubble();
    test_single();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
